demux_3o_buffered: RTL and testbench

//  Registered 1-to-3 demultiplexer with valid/ready handshake: the write-side

---
 rtl/demux_3o_buffered_pkg.sv | 17 +
 rtl/demux_3o_buffered_if.sv | 29 ++
 rtl/demux_3o_buffered_out_slot.sv | 43 ++++
 rtl/demux_3o_buffered.sv | 75 +++++++
 tb/tb_demux_3o_buffered.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_3o_buffered_pkg.sv
// Shared constants and types for the buffered 1-to-3 write-back demultiplexer.
package demux_3o_buffered_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned NUM_DEST      = 3;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [0:0] {
    SlotEmpty,
    SlotFull
  } slot_state_e;

endpackage

// File: rtl/demux_3o_buffered_if.sv
// Source-side and destination-side handshake bundle of the buffered demultiplexer.
interface demux_3o_buffered_if #(
  parameter int unsigned WIDTH  = demux_3o_buffered_pkg::DEFAULT_WIDTH,
  parameter int unsigned DROP_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic [WIDTH-1:0]  in_data;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [WIDTH-1:0]  out_data_a;
  logic [WIDTH-1:0]  out_data_b;
  logic [WIDTH-1:0]  out_data_c;
  logic              err_sel;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data_a, out_data_b, out_data_c, err_sel, drop_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data_a, out_data_b, out_data_c, err_sel, drop_cnt
  );

endinterface

// File: rtl/demux_3o_buffered_out_slot.sv
// One-entry holding slot: EMPTY/FULL state plus a data register that only changes on load.
module demux_3o_buffered_out_slot
  import demux_3o_buffered_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) data_d = load_data_i;
    unique case (state_q)
      SlotEmpty: if (load_i) state_d = SlotFull;
      // A drain in the same cycle as a load keeps the slot full.
      SlotFull:  if (ready_i && !load_i) state_d = SlotEmpty;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SlotEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SlotFull);
  assign data_o  = data_q;

endmodule

// File: rtl/demux_3o_buffered.sv
// Registered 1-to-3 demultiplexer with per-destination holding slots, select-error pulse
// and a saturating count of words dropped for an invalid select.
module demux_3o_buffered
  import demux_3o_buffered_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DROP_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  demux_3o_buffered_if.slave bus
);

  logic [NUM_DEST-1:0] sel_hot;
  logic [NUM_DEST-1:0] load;
  logic [NUM_DEST-1:0] slot_valid;
  logic [WIDTH-1:0]    slot_data [NUM_DEST];
  logic                accept;
  logic                drop;
  logic                err_sel_q;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  always_comb begin
    sel_hot = '0;
    unique case (bus.in_sel)
      SEL_A:    sel_hot = 3'b001;
      SEL_B:    sel_hot = 3'b010;
      SEL_C:    sel_hot = 3'b100;
      SEL_NONE: sel_hot = 3'b000;
    endcase
  end

  // Depends only on select and slot status, never on in_valid.
  assign bus.in_ready = (bus.in_sel == SEL_NONE) | (|(sel_hot & (~slot_valid | bus.out_ready)));
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = {NUM_DEST{accept}} & sel_hot;
  assign drop         = accept & (bus.in_sel == SEL_NONE);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_sel_q  <= drop;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_slot
    demux_3o_buffered_out_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .load_i      (load[i]),
      .load_data_i (bus.in_data),
      .ready_i     (bus.out_ready[i]),
      .valid_o     (slot_valid[i]),
      .data_o      (slot_data[i])
    );
  end

  assign bus.out_valid  = slot_valid;
  assign bus.out_data_a = slot_data[0];
  assign bus.out_data_b = slot_data[1];
  assign bus.out_data_c = slot_data[2];
  assign bus.err_sel    = err_sel_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_demux_3o_buffered.sv
// Directed vector table, multi-cycle corner sequences and a queue-scoreboarded random run.
module tb_demux_3o_buffered;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  demux_3o_buffered_if #(.WIDTH(16), .DROP_W(8)) bus ();

  demux_3o_buffered #(
    .WIDTH  (16),
    .DROP_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [2:0]  ordy;
    logic        exp_ir;
    logic [2:0]  exp_ov;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [15:0] exp_c;
    logic        exp_err;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs [18];

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [15:0] data,
                       input logic [2:0] ordy);
    bus.in_valid  = vld;
    bus.in_sel    = sel;
    bus.in_data   = data;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] out_data(input int i);
    case (i)
      0:       return bus.out_data_a;
      1:       return bus.out_data_b;
      default: return bus.out_data_c;
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [15:0] q_pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void q_push(input int i, input logic [15:0] d);
    case (i)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endfunction

  initial begin
    logic        ir_exp;
    logic [2:0]  ov_exp;
    logic [1:0]  rsel;
    logic        rvld;
    logic [2:0]  rordy;
    logic [15:0] rdata;
    int          r;

    //           vld   sel   data      ordy    ir    ov      a         b         c       err  drop
    vecs[0]  = '{1'b1, 2'd0, 16'h1234, 3'b111, 1'b1, 3'b001, 16'h1234, 16'h0000, 16'h0000, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 2'd1, 16'hABCD, 3'b111, 1'b1, 3'b010, 16'h1234, 16'hABCD, 16'h0000, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 2'd2, 16'h00FF, 3'b111, 1'b1, 3'b100, 16'h1234, 16'hABCD, 16'h00FF, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 2'd0, 16'h0000, 3'b111, 1'b1, 3'b000, 16'h1234, 16'hABCD, 16'h00FF, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 2'd1, 16'h0001, 3'b101, 1'b1, 3'b010, 16'h1234, 16'h0001, 16'h00FF, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 2'd1, 16'h0002, 3'b101, 1'b0, 3'b010, 16'h1234, 16'h0001, 16'h00FF, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 2'd0, 16'h0A0A, 3'b101, 1'b1, 3'b011, 16'h0A0A, 16'h0001, 16'h00FF, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 2'd1, 16'h0002, 3'b111, 1'b1, 3'b010, 16'h0A0A, 16'h0002, 16'h00FF, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 2'd1, 16'h0000, 3'b111, 1'b1, 3'b000, 16'h0A0A, 16'h0002, 16'h00FF, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 2'd3, 16'hDEAD, 3'b000, 1'b1, 3'b000, 16'h0A0A, 16'h0002, 16'h00FF, 1'b1, 8'd1};
    vecs[10] = '{1'b1, 2'd3, 16'hBEEF, 3'b000, 1'b1, 3'b000, 16'h0A0A, 16'h0002, 16'h00FF, 1'b1, 8'd2};
    vecs[11] = '{1'b0, 2'd3, 16'h0000, 3'b000, 1'b1, 3'b000, 16'h0A0A, 16'h0002, 16'h00FF, 1'b0, 8'd2};
    vecs[12] = '{1'b1, 2'd3, 16'h5555, 3'b000, 1'b1, 3'b000, 16'h0A0A, 16'h0002, 16'h00FF, 1'b1, 8'd3};
    vecs[13] = '{1'b0, 2'd0, 16'h0000, 3'b000, 1'b1, 3'b000, 16'h0A0A, 16'h0002, 16'h00FF, 1'b0, 8'd3};
    vecs[14] = '{1'b1, 2'd0, 16'h1111, 3'b000, 1'b1, 3'b001, 16'h1111, 16'h0002, 16'h00FF, 1'b0, 8'd3};
    vecs[15] = '{1'b1, 2'd0, 16'h2222, 3'b000, 1'b0, 3'b001, 16'h1111, 16'h0002, 16'h00FF, 1'b0, 8'd3};
    vecs[16] = '{1'b1, 2'd3, 16'h7777, 3'b000, 1'b1, 3'b001, 16'h1111, 16'h0002, 16'h00FF, 1'b1, 8'd4};
    vecs[17] = '{1'b0, 2'd0, 16'h0000, 3'b001, 1'b1, 3'b000, 16'h1111, 16'h0002, 16'h00FF, 1'b0, 8'd4};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 16'h0000, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset out_valid", 32'(bus.out_valid), 32'h0);
    check("reset data_a", 32'(bus.out_data_a), 32'h0);
    check("reset data_b", 32'(bus.out_data_b), 32'h0);
    check("reset data_c", 32'(bus.out_data_c), 32'h0);
    check("reset err_sel", 32'(bus.err_sel), 32'h0);
    check("reset drop_cnt", 32'(bus.drop_cnt), 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ir));
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d data_a", i), 32'(bus.out_data_a), 32'(vecs[i].exp_a));
      check($sformatf("vec%0d data_b", i), 32'(bus.out_data_b), 32'(vecs[i].exp_b));
      check($sformatf("vec%0d data_c", i), 32'(bus.out_data_c), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d err_sel", i), 32'(bus.err_sel), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d drop_cnt", i), 32'(bus.drop_cnt), 32'(vecs[i].exp_drop));
    end

    // Throughput: A already full, drained and refilled every cycle.
    drive(1'b1, 2'd0, 16'h0100, 3'b001);
    tick();
    check("thr prefill valid", 32'(bus.out_valid), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 2'd0, 16'h0100 + 16'(k), 3'b001);
      #1;
      check($sformatf("thr%0d in_ready", k), 32'(bus.in_ready), 32'h1);
      tick();
      check($sformatf("thr%0d valid", k), 32'(bus.out_valid), 32'h1);
      check($sformatf("thr%0d data_a", k), 32'(bus.out_data_a), 32'h0100 + 32'(k));
    end
    drive(1'b0, 2'd0, 16'h0000, 3'b001);
    tick();
    check("thr drained", 32'(bus.out_valid), 32'h0);

    // Saturation of the drop counter, starting from 4.
    for (int k = 0; k < 253; k++) begin
      drive(1'b1, 2'd3, 16'(k), 3'b000);
      tick();
      if (k >= 250) begin
        check($sformatf("sat%0d err_sel", k), 32'(bus.err_sel), 32'h1);
        check($sformatf("sat%0d drop_cnt", k), 32'(bus.drop_cnt), 32'hFF);
      end
    end
    check("sat out_valid", 32'(bus.out_valid), 32'h0);
    drive(1'b0, 2'd0, 16'h0000, 3'b000);
    tick();
    check("sat idle err_sel", 32'(bus.err_sel), 32'h0);
    check("sat idle drop_cnt", 32'(bus.drop_cnt), 32'hFF);

    // Asynchronous reset with all slots full.
    drive(1'b1, 2'd0, 16'hAAAA, 3'b000);
    tick();
    drive(1'b1, 2'd1, 16'hBBBB, 3'b000);
    tick();
    drive(1'b1, 2'd2, 16'hCCCC, 3'b000);
    tick();
    drive(1'b0, 2'd0, 16'h0000, 3'b000);
    check("pre-rst out_valid", 32'(bus.out_valid), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(bus.out_valid), 32'h0);
    check("async rst data_a", 32'(bus.out_data_a), 32'h0);
    check("async rst data_b", 32'(bus.out_data_b), 32'h0);
    check("async rst data_c", 32'(bus.out_data_c), 32'h0);
    check("async rst drop_cnt", 32'(bus.drop_cnt), 32'h0);
    drive(1'b1, 2'd1, 16'h9999, 3'b111);
    repeat (2) tick();
    check("held rst out_valid", 32'(bus.out_valid), 32'h0);
    check("held rst data_b", 32'(bus.out_data_b), 32'h0);
    drive(1'b0, 2'd0, 16'h0000, 3'b000);
    rst_n = 1'b1;
    tick();
    check("post rst out_valid", 32'(bus.out_valid), 32'h0);
    check("post rst err_sel", 32'(bus.err_sel), 32'h0);

    // Random traffic against per-destination queues; last cycles flush everything.
    for (int cyc = 0; cyc < 10003; cyc++) begin
      if (cyc < 10000) begin
        r     = int'($urandom_range(0, 9));
        rsel  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        rvld  = ($urandom_range(0, 3) != 0);
        rordy = 3'($urandom_range(0, 7));
        rdata = 16'($urandom_range(0, 65535));
      end else begin
        rsel  = 2'd0;
        rvld  = 1'b0;
        rordy = 3'b111;
        rdata = 16'h0000;
      end
      drive(rvld, rsel, rdata, rordy);
      #1;
      for (int i = 0; i < 3; i++) ov_exp[i] = (q_size(i) != 0);
      ir_exp = (rsel == 2'd3) || (q_size(int'(rsel)) == 0) || rordy[rsel];
      check("rnd out_valid", 32'(bus.out_valid), 32'(ov_exp));
      check("rnd in_ready", 32'(bus.in_ready), 32'(ir_exp));
      for (int i = 0; i < 3; i++) begin
        if (ov_exp[i] && rordy[i]) check($sformatf("rnd drain%0d", i), 32'(out_data(i)),
                                         32'(q_pop(i)));
      end
      if (rvld && ir_exp && rsel != 2'd3) q_push(int'(rsel), rdata);
      tick();
    end
    check("rnd final out_valid", 32'(bus.out_valid), 32'h0);
    check("rnd leftover", 32'(q0.size() + q1.size() + q2.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
